// File: rtl/zimbo_pkg.sv
// Shared definitions for the Zimbo 16-bit multi-cycle core: opcodes, field positions, FSM states.
package zimbo_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_LDI  = 5'b01011;
  localparam logic [4:0] OP_LUI  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01101;
  localparam logic [4:0] OP_ST   = 5'b01110;
  localparam logic [4:0] OP_ADDI = 5'b01111;
  localparam logic [4:0] OP_JR   = 5'b10000;
  localparam logic [4:0] OP_BEQZ = 5'b10001;
  localparam logic [4:0] OP_BNEZ = 5'b10010;
  localparam logic [4:0] OP_JMP  = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 2;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // True for opcodes whose rd is written with the ALU result.
  function automatic logic alu_writes(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_LUI)) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/zimbo_alu.sv
// Combinational datapath for Zimbo register/immediate operations; b carries rs2 (or old rd for LUI).
module zimbo_alu
  import zimbo_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  imm,
  output logic [15:0] result
);

  logic [3:0]  sh;
  logic [31:0] rot_l;
  logic [31:0] rot_r;

  always_comb begin
    sh     = imm[3:0];
    // Rotates via a doubled operand so a zero shift needs no special case.
    rot_l  = {a, a} << sh;
    rot_r  = {a, a} >> sh;
    result = 16'h0000;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << sh;
      OP_SHR:  result = a >> sh;
      OP_ROL:  result = rot_l[31:16];
      OP_ROR:  result = rot_r[15:0];
      OP_LDI:  result = {8'h00, imm};
      OP_LUI:  result = {imm, b[7:0]};
      OP_ADDI: result = a + {{11{imm[4]}}, imm[4:0]};
      default: result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/zimbo_top.sv
// Zimbo core: two-cycle FETCH/EXEC sequencer with eight 16-bit registers over one memory bus.
module zimbo_top
  import zimbo_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] addrm,
  output logic [15:0] wmdata,
  output logic        memwr_en,
  input  logic [15:0] rmdata
);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] rd_val, rs1_val, rs2_val;
  logic [15:0] alu_b, alu_result;
  logic [15:0] mem_addr, br_target, jmp_target;

  assign opcode     = ir_q[OP_MSB:OP_LSB];
  assign rd         = ir_q[RD_MSB:RD_LSB];
  assign rs1        = ir_q[RS1_MSB:RS1_LSB];
  assign rs2        = ir_q[RS2_MSB:RS2_LSB];
  assign rd_val     = regs_q[rd];
  assign rs1_val    = regs_q[rs1];
  assign rs2_val    = regs_q[rs2];
  assign alu_b      = (opcode == OP_LUI) ? rd_val : rs2_val;
  assign mem_addr   = {rs1_val[15:1], 1'b0};
  // pc_q already points past the branch, so offsets are relative to the next instruction.
  assign br_target  = pc_q + {{7{ir_q[7]}}, ir_q[7:0], 1'b0};
  assign jmp_target = pc_q + {{4{ir_q[10]}}, ir_q[10:0], 1'b0};

  zimbo_alu u_alu (
    .op     (opcode),
    .a      (rs1_val),
    .b      (alu_b),
    .imm    (ir_q[7:0]),
    .result (alu_result)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    addrm    = pc_q;
    wmdata   = 16'h0000;
    memwr_en = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = rmdata;
        pc_d    = pc_q + 16'd2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == HALT_OP) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          case (opcode)
            OP_LD: begin
              addrm      = mem_addr;
              regs_d[rd] = rmdata;
            end
            OP_ST: begin
              addrm    = mem_addr;
              wmdata   = rd_val;
              memwr_en = 1'b1;
            end
            OP_JR:   pc_d = rs1_val & 16'hFFFE;
            OP_BEQZ: if (rd_val == 16'h0000) pc_d = br_target;
            OP_BNEZ: if (rd_val != 16'h0000) pc_d = br_target;
            OP_JMP:  pc_d = jmp_target;
            default: if (alu_writes(opcode)) regs_d[rd] = alu_result;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_zimbo_top.sv
// Directed bench for zimbo_top with a behavioural word memory the bench can also drive after HALT.
module tb_zimbo_top;
  import zimbo_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [15:0] addrm;
  logic [15:0] wmdata;
  logic        memwr_en;
  logic [15:0] rmdata;

  logic        tb_own;
  logic [15:0] tb_addr;
  logic [15:0] tb_wdata;
  logic        tb_we;

  logic [15:0] mem [1024];
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;

  int checks;
  int errors;
  int wr_cnt;
  int addi_cnt;
  int wr_base;
  int addi_base;
  logic halt_bus_wr;

  zimbo_top dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addrm    (addrm),
    .wmdata   (wmdata),
    .memwr_en (memwr_en),
    .rmdata   (rmdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_addr  = tb_own ? tb_addr  : addrm;
  assign mem_wdata = tb_own ? tb_wdata : wmdata;
  assign mem_we    = tb_own ? tb_we    : memwr_en;
  assign rmdata    = mem[mem_addr[10:1]];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[10:1]] <= mem_wdata;
  end

  always @(negedge clock) begin
    if (memwr_en) wr_cnt <= wr_cnt + 1;
    if (memwr_en && tb_own) halt_bus_wr <= 1'b1;
    if (dut.state_q == ST_EXEC && dut.opcode == OP_ADDI) addi_cnt <= addi_cnt + 1;
  end

  function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [4:0] imm5);
    return {op, rd, rs1, imm5};
  endfunction

  function automatic logic [15:0] i8(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [7:0] imm8);
    return {op, rd, imm8};
  endfunction

  localparam logic [15:0] HALT_W = {OP_HALT, 11'h000};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
    tb_own   = 1'b1;
    tb_addr  = a;
    tb_wdata = d;
    tb_we    = 1'b1;
    @(posedge clock);
    #1;
    tb_we    = 1'b0;
  endtask

  task automatic enter_reset();
    @(negedge clock);
    reset_n = 1'b0;
    tb_own  = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    tb_own    = 1'b0;
    wr_base   = wr_cnt;
    addi_base = addi_cnt;
    reset_n   = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (dut.state_q == ST_HALT) break;
      @(posedge clock);
      #1;
    end
    chk(tag, {14'h0, dut.state_q}, {14'h0, ST_HALT});
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    wr_cnt      = 0;
    addi_cnt    = 0;
    halt_bus_wr = 1'b0;
    tb_own      = 1'b1;
    tb_addr     = 16'h0000;
    tb_wdata    = 16'h0000;
    tb_we       = 1'b0;
    reset_n     = 1'b0;

    // Reset and first program: LDI R1,5; HALT
    mem_write(16'h0000, i8(OP_LDI, 3'd1, 8'h05));
    mem_write(16'h0002, HALT_W);
    tb_own = 1'b0;
    #1;
    chk("reset_addrm", addrm, 16'h0000);
    chk("reset_memwr", {15'h0, memwr_en}, 16'h0000);
    chk("reset_wmdata", wmdata, 16'h0000);
    chk("reset_opcode", {11'h0, dut.opcode}, {11'h0, OP_NOP});
    release_reset();
    cycles(3);
    chk("halt_opcode_cycle4", {11'h0, dut.opcode}, {11'h0, OP_HALT});
    chk("ldi_r1", dut.regs_q[1], 16'h0005);
    cycles(3);
    chk("halt_state", {14'h0, dut.state_q}, {14'h0, ST_HALT});
    chk("halt_pc", dut.pc_q, 16'h0004);
    chk("halt_addrm", addrm, 16'h0004);

    // ALU program with R1=0x00F0, R2=0x0F0F
    enter_reset();
    mem_write(16'h0000, i8(OP_LDI, 3'd1, 8'hF0));
    mem_write(16'h0002, i8(OP_LDI, 3'd2, 8'h0F));
    mem_write(16'h0004, i8(OP_LUI, 3'd2, 8'h0F));
    mem_write(16'h0006, rr(OP_ADD, 3'd3, 3'd1, 3'd2));
    mem_write(16'h0008, rr(OP_XOR, 3'd4, 3'd1, 3'd2));
    mem_write(16'h000A, rr(OP_SUB, 3'd5, 3'd2, 3'd1));
    mem_write(16'h000C, ri(OP_ROL, 3'd6, 3'd1, 5'd4));
    mem_write(16'h000E, ri(OP_ADDI, 3'd7, 3'd1, 5'h1F));
    mem_write(16'h0010, ri(OP_SHR, 3'd0, 3'd2, 5'd4));
    mem_write(16'h0012, HALT_W);
    release_reset();
    run_to_halt("alu_halt", 100);
    chk("lui_r2", dut.regs_q[2], 16'h0F0F);
    chk("add_r3", dut.regs_q[3], 16'h0FFF);
    chk("xor_r4", dut.regs_q[4], 16'h0FFF);
    chk("sub_r5", dut.regs_q[5], 16'h0E1F);
    chk("rol_r6", dut.regs_q[6], 16'h0F00);
    chk("addi_r7", dut.regs_q[7], 16'h00EF);
    chk("shr_r0", dut.regs_q[0], 16'h00F0);

    // Store/load round trip through byte address 460
    enter_reset();
    mem_write(16'd460, 16'h0000);
    mem_write(16'h0000, i8(OP_LDI, 3'd1, 8'hCC));
    mem_write(16'h0002, i8(OP_LUI, 3'd1, 8'hBA));
    mem_write(16'h0004, i8(OP_LDI, 3'd2, 8'hCC));
    mem_write(16'h0006, i8(OP_LUI, 3'd2, 8'h01));
    mem_write(16'h0008, rr(OP_ST, 3'd1, 3'd2, 3'd0));
    mem_write(16'h000A, rr(OP_LD, 3'd3, 3'd2, 3'd0));
    mem_write(16'h000C, HALT_W);
    release_reset();
    run_to_halt("mem_halt", 100);
    chk("st_mem460", mem[230], 16'hBACC);
    chk("ld_r3", dut.regs_q[3], 16'hBACC);
    chk("st_pulse_count", 16'(wr_cnt - wr_base), 16'd1);

    // Bench owns the bus after HALT
    halt_bus_wr = 1'b0;
    mem_write(16'd462, 16'h1234);
    tb_addr = 16'd460;
    #1;
    chk("bus_read460", rmdata, 16'hBACC);
    tb_addr = 16'd462;
    #1;
    chk("bus_read462", rmdata, 16'h1234);
    cycles(20);
    chk("halt_no_memwr", {15'h0, halt_bus_wr}, 16'h0000);
    chk("halt_mem460_kept", mem[230], 16'hBACC);

    // Countdown loop with BNEZ, then JMP over one instruction
    enter_reset();
    mem_write(16'h0000, i8(OP_LDI, 3'd1, 8'h03));
    mem_write(16'h0002, ri(OP_ADDI, 3'd1, 3'd1, 5'h1F));
    mem_write(16'h0004, i8(OP_BNEZ, 3'd1, 8'hFE));
    mem_write(16'h0006, i8(OP_LDI, 3'd2, 8'h77));
    mem_write(16'h0008, {OP_JMP, 11'h001});
    mem_write(16'h000A, i8(OP_LDI, 3'd2, 8'hEE));
    mem_write(16'h000C, HALT_W);
    release_reset();
    run_to_halt("loop_halt", 200);
    chk("loop_iterations", 16'(addi_cnt - addi_base), 16'd3);
    chk("loop_r1", dut.regs_q[1], 16'h0000);
    chk("jmp_skip_r2", dut.regs_q[2], 16'h0077);
    chk("loop_pc", dut.pc_q, 16'h000E);

    // Reset pulsed during the FETCH of a ST
    enter_reset();
    mem_write(16'h0040, 16'h0000);
    mem_write(16'h0000, i8(OP_LDI, 3'd1, 8'h55));
    mem_write(16'h0002, i8(OP_LDI, 3'd2, 8'h40));
    mem_write(16'h0004, rr(OP_ST, 3'd1, 3'd2, 3'd0));
    mem_write(16'h0006, HALT_W);
    release_reset();
    cycles(4);
    chk("pre_st_fetch_pc", dut.pc_q, 16'h0004);
    reset_n = 1'b0;
    #1;
    chk("midreset_pc", dut.pc_q, 16'h0000);
    chk("midreset_addrm", addrm, 16'h0000);
    chk("midreset_memwr", {15'h0, memwr_en}, 16'h0000);
    cycles(2);
    chk("midreset_no_store", mem[32], 16'h0000);
    chk("midreset_no_pulse", 16'(wr_cnt - wr_base), 16'd0);
    release_reset();
    run_to_halt("restart_halt", 100);
    chk("restart_store", mem[32], 16'h0055);
    chk("restart_pulse", 16'(wr_cnt - wr_base), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
